// File: rtl/fir_seq_ctrl_if.sv
// Sample/coefficient/result bundle between fir_seq_ctrl and its neighbours.
// Latency: none (wires only).
// Backpressure: org_valid/org_ready on input samples, fil_valid/fil_ready on results.
// Ports: sound_org/org_valid/org_ready in, coef_we/coef_addr/coef_data writes,
//        sound_fil/fil_sat/fil_valid/fil_ready out, busy status.
interface fir_seq_ctrl_if #(
  parameter int NTAPS = 16
);
  logic signed [23:0]        sound_org;
  logic                      org_valid;
  logic                      org_ready;
  logic                      coef_we;
  logic [$clog2(NTAPS)-1:0]  coef_addr;
  logic signed [23:0]        coef_data;
  logic signed [23:0]        sound_fil;
  logic                      fil_valid;
  logic                      fil_ready;
  logic                      fil_sat;
  logic                      busy;

  modport master (
    output sound_org, org_valid, coef_we, coef_addr, coef_data, fil_ready,
    input  org_ready, sound_fil, fil_valid, fil_sat, busy
  );

  modport slave (
    input  sound_org, org_valid, coef_we, coef_addr, coef_data, fil_ready,
    output org_ready, sound_fil, fil_valid, fil_sat, busy
  );
endinterface

// File: rtl/fir_seq_ctrl.sv
// Sequential FIR: one shared 24x24 multiplier, one tap per cycle, circular history.
// Latency: sample accepted at cycle T -> fil_valid first at T+NTAPS+1.
// Backpressure: result held in DONE until fil_ready; org_ready only in IDLE.
// Ports: clk (rising edge), rst (async, active-low), bus (slave side of
//        fir_seq_ctrl_if: sample in, coefficient writes, filtered result out, busy).
module fir_seq_ctrl #(
  parameter int NTAPS = 16,
  parameter int FRAC  = 23
) (
  input  logic          clk,
  input  logic          rst,
  fir_seq_ctrl_if.slave bus
);
  localparam int AW   = $clog2(NTAPS);
  localparam int ACCW = 48 + AW;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [23:0]     coef_q [NTAPS];
  logic signed [23:0]     coef_d [NTAPS];
  logic signed [23:0]     hist_q [NTAPS];
  logic signed [23:0]     hist_d [NTAPS];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          tap_q, tap_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic signed [23:0]     sound_fil_q, sound_fil_d;
  logic                   fil_sat_q, fil_sat_d;
  logic                   fil_valid_q, fil_valid_d;
  logic                   busy_q, busy_d;
  logic                   org_ready_q, org_ready_d;

  logic [AW-1:0]          rd_idx;
  logic signed [47:0]     coef_x, hist_x, prod;
  logic signed [ACCW-1:0] acc_sum, acc_shr;
  logic signed [23:0]     sat_val;
  logic                   sat_flag;

  // wr_ptr already points past the newest sample, so tap k reads (wr_ptr-1-k).
  assign rd_idx  = wr_ptr_q - AW'(1) - tap_q;
  assign coef_x  = 48'(coef_q[tap_q]);
  assign hist_x  = 48'(hist_q[rd_idx]);
  assign prod    = coef_x * hist_x;
  assign acc_sum = acc_q + ACCW'(prod);
  assign acc_shr = acc_sum >>> FRAC;

  // In range only when every bit from 23 upward is a copy of the sign.
  always_comb begin
    sat_flag = !((&acc_shr[ACCW-1:23]) || !(|acc_shr[ACCW-1:23]));
    if (!sat_flag) begin
      sat_val = acc_shr[23:0];
    end else if (acc_shr[ACCW-1]) begin
      sat_val = 24'sh800000;
    end else begin
      sat_val = 24'sh7FFFFF;
    end
  end

  always_comb begin
    state_d     = state_q;
    coef_d      = coef_q;
    hist_d      = hist_q;
    wr_ptr_d    = wr_ptr_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    sound_fil_d = sound_fil_q;
    fil_sat_d   = fil_sat_q;
    case (state_q)
      IDLE: begin
        // Coefficient write lands before the MAC pass reads it next cycle.
        if (bus.coef_we) begin
          coef_d[bus.coef_addr] = bus.coef_data;
        end
        if (bus.org_valid) begin
          hist_d[wr_ptr_q] = bus.sound_org;
          wr_ptr_d         = wr_ptr_q + AW'(1);
          acc_d            = '0;
          tap_d            = '0;
          state_d          = MAC;
        end
      end
      MAC: begin
        acc_d = acc_sum;
        tap_d = tap_q + AW'(1);
        if (tap_q == AW'(NTAPS - 1)) begin
          sound_fil_d = sat_val;
          fil_sat_d   = sat_flag;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (bus.fil_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    fil_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
    org_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      for (int i = 0; i < NTAPS; i++) begin
        coef_q[i] <= '0;
        hist_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      tap_q       <= '0;
      acc_q       <= '0;
      sound_fil_q <= '0;
      fil_sat_q   <= 1'b0;
      fil_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      org_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      coef_q      <= coef_d;
      hist_q      <= hist_d;
      wr_ptr_q    <= wr_ptr_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      sound_fil_q <= sound_fil_d;
      fil_sat_q   <= fil_sat_d;
      fil_valid_q <= fil_valid_d;
      busy_q      <= busy_d;
      org_ready_q <= org_ready_d;
    end
  end

  assign bus.org_ready = org_ready_q;
  assign bus.sound_fil = sound_fil_q;
  assign bus.fil_sat   = fil_sat_q;
  assign bus.fil_valid = fil_valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Bench for fir_seq_ctrl: directed scenarios plus random traffic against a
// behavioural model (sample list newest-first, dot product, shift, clamp).
module tb_fir_seq_ctrl;
  localparam int NTAPS = 16;
  localparam int FRAC  = 23;

  logic clk;
  logic rst;
  fir_seq_ctrl_if #(.NTAPS(NTAPS)) bus ();

  fir_seq_ctrl #(.NTAPS(NTAPS), .FRAC(FRAC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mcoef [NTAPS];
  int          hist_q[$];
  logic [23:0] exp_y[$];
  logic        exp_s[$];
  logic [23:0] out_y[$];
  logic        out_s[$];
  bit          in_flight = 1'b0;
  int          acc_cyc   = 0;
  bit          exp_vld;
  longint      m_sum, m_sh;

  always @(negedge clk) begin
    if (!rst) begin
      if (mon_en) begin
        check("rst_fil_valid", {31'b0, bus.fil_valid}, 32'd0);
        check("rst_sound_fil", {8'b0, bus.sound_fil}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
      end
      hist_q.delete();
      exp_y.delete();
      exp_s.delete();
      for (int k = 0; k < NTAPS; k++) mcoef[k] = 0;
      in_flight = 1'b0;
    end else if (mon_en) begin
      exp_vld = in_flight && (cyc >= acc_cyc + NTAPS + 1);
      check("fil_valid", {31'b0, bus.fil_valid}, {31'b0, exp_vld});
      check("org_ready", {31'b0, bus.org_ready}, {31'b0, !in_flight});
      check("busy", {31'b0, bus.busy}, {31'b0, in_flight});
      if (exp_vld) begin
        check("sound_fil", {8'b0, bus.sound_fil}, {8'b0, exp_y[0]});
        check("fil_sat", {31'b0, bus.fil_sat}, {31'b0, exp_s[0]});
      end
      if (exp_vld && bus.fil_ready) begin
        out_y.push_back(bus.sound_fil);
        out_s.push_back(bus.fil_sat);
        void'(exp_y.pop_front());
        void'(exp_s.pop_front());
        in_flight = 1'b0;
      end else if (!in_flight) begin
        if (bus.coef_we) mcoef[bus.coef_addr] = int'(bus.coef_data);
        if (bus.org_valid) begin
          hist_q.push_front(int'(bus.sound_org));
          if (hist_q.size() > NTAPS) void'(hist_q.pop_back());
          m_sum = 0;
          for (int k = 0; k < hist_q.size(); k++)
            m_sum += longint'(mcoef[k]) * longint'(hist_q[k]);
          m_sh = m_sum >>> FRAC;
          if (m_sh > 64'sd8388607) begin
            exp_y.push_back(24'h7FFFFF); exp_s.push_back(1'b1);
          end else if (m_sh < -64'sd8388608) begin
            exp_y.push_back(24'h800000); exp_s.push_back(1'b1);
          end else begin
            exp_y.push_back(m_sh[23:0]); exp_s.push_back(1'b0);
          end
          in_flight = 1'b1;
          acc_cyc   = cyc;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int g = 0; g < 200 && !bus.org_ready; g++) step();
    if (!bus.org_ready) check("org_ready_wait", {31'b0, bus.org_ready}, 32'd1);
  endtask

  task automatic send_sample(input logic [23:0] x, input logic we, input logic [3:0] addr,
                             input logic [23:0] data, output int t_acc);
    wait_ready();
    bus.sound_org = x;
    bus.org_valid = 1'b1;
    bus.coef_we   = we;
    bus.coef_addr = addr;
    bus.coef_data = data;
    t_acc = cyc;
    step();
    bus.org_valid = 1'b0;
    bus.coef_we   = 1'b0;
  endtask

  task automatic send(input logic [23:0] x);
    int t;
    send_sample(x, 1'b0, 4'd0, 24'd0, t);
  endtask

  task automatic load_coef(input int k, input logic [23:0] v);
    wait_ready();
    bus.coef_we   = 1'b1;
    bus.coef_addr = k[3:0];
    bus.coef_data = v;
    step();
    bus.coef_we   = 1'b0;
  endtask

  task automatic wait_outs(input int n);
    for (int g = 0; g < 3000 && out_y.size() < n; g++) step();
    check("outs_wait", {31'b0, out_y.size() >= n}, 32'd1);
  endtask

  task automatic impulse_test(input string tag);
    int base;
    for (int k = 0; k < NTAPS; k++) load_coef(k, 24'h100000);
    base = out_y.size();
    send(24'h400000);
    for (int i = 0; i < 17; i++) send(24'h000000);
    wait_outs(base + 18);
    if (out_y.size() >= base + 18) begin
      for (int i = 0; i < 16; i++) begin
        check({tag, "_tap"}, {8'b0, out_y[base+i]}, 32'h080000);
        check({tag, "_sat"}, {31'b0, out_s[base+i]}, 32'd0);
      end
      check({tag, "_out17"}, {8'b0, out_y[base+16]}, 32'h000000);
      check({tag, "_out17_sat"}, {31'b0, out_s[base+16]}, 32'd0);
    end
  endtask

  int t_acc, t_v, base;
  logic [23:0] held;

  initial begin
    rst = 1'b1;
    bus.sound_org = '0; bus.org_valid = 1'b0; bus.coef_we = 1'b0;
    bus.coef_addr = '0; bus.coef_data = '0; bus.fil_ready = 1'b1;
    #2 rst = 1'b0;
    mon_en = 1'b1;
    #1;
    check("reset_fil_valid", {31'b0, bus.fil_valid}, 32'd0);
    check("reset_busy", {31'b0, bus.busy}, 32'd0);
    check("reset_fil_sat", {31'b0, bus.fil_sat}, 32'd0);
    check("reset_sound_fil", {8'b0, bus.sound_fil}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    step();
    check("reset_org_ready", {31'b0, bus.org_ready}, 32'd1);

    // impulse response
    impulse_test("impulse");

    // latency and backpressure
    bus.fil_ready = 1'b0;
    send_sample(24'h123456, 1'b0, 4'd0, 24'd0, t_acc);
    t_v = t_acc;
    for (int g = 0; g < 100 && !bus.fil_valid; g++) step();
    t_v = cyc;
    check("latency", t_v - t_acc, 32'd17);
    held = bus.sound_fil;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_stable", {8'b0, bus.sound_fil}, {8'b0, held});
      check("bp_org_ready", {31'b0, bus.org_ready}, 32'd0);
      check("bp_busy", {31'b0, bus.busy}, 32'd1);
    end
    bus.fil_ready = 1'b1;
    step();

    // coefficient write ignored while busy, honoured together with an accept in IDLE
    for (int k = 0; k < NTAPS; k++) load_coef(k, 24'h000000);
    base = out_y.size();
    send(24'h400000);
    bus.coef_we = 1'b1; bus.coef_addr = 4'd0; bus.coef_data = 24'h7FFFFF;
    repeat (3) step();
    bus.coef_we = 1'b0;
    wait_outs(base + 1);
    if (out_y.size() >= base + 1) check("coef_busy_ignored", {8'b0, out_y[base]}, 32'h000000);
    send_sample(24'h400000, 1'b1, 4'd0, 24'h7FFFFF, t_acc);
    wait_outs(base + 2);
    if (out_y.size() >= base + 2) check("coef_idle_used", {8'b0, out_y[base+1]}, 32'h3FFFFF);

    // saturation both directions
    for (int k = 0; k < NTAPS; k++) load_coef(k, 24'h7FFFFF);
    base = out_y.size();
    for (int i = 0; i < 16; i++) send(24'h7FFFFF);
    wait_outs(base + 16);
    if (out_y.size() >= base + 16) begin
      check("sat_pos", {8'b0, out_y[base+15]}, 32'h7FFFFF);
      check("sat_pos_flag", {31'b0, out_s[base+15]}, 32'd1);
    end
    base = out_y.size();
    for (int i = 0; i < 16; i++) send(24'h800000);
    wait_outs(base + 16);
    if (out_y.size() >= base + 16) begin
      check("sat_neg", {8'b0, out_y[base+15]}, 32'h800000);
      check("sat_neg_flag", {31'b0, out_s[base+15]}, 32'd1);
    end

    // reset at tap 7 of a pass
    send_sample(24'h7FFFFF, 1'b0, 4'd0, 24'd0, t_acc);
    repeat (7) step();
    rst = 1'b0;
    #1;
    check("midmac_fil_valid", {31'b0, bus.fil_valid}, 32'd0);
    check("midmac_sound_fil", {8'b0, bus.sound_fil}, 32'd0);
    repeat (2) step();
    rst = 1'b1;
    step();
    impulse_test("post_reset");

    // ramp across pointer wrap
    for (int k = 0; k < NTAPS; k++)
      load_coef(k, (k == 0) ? 24'h7FFFFF : (24'h800000 >> k));
    base = out_y.size();
    for (int i = 1; i <= 40; i++) send(24'(i));
    wait_outs(base + 40);
    if (out_y.size() >= base + 3) begin
      check("ramp_out1", {8'b0, out_y[base]}, 32'd0);
      check("ramp_out2", {8'b0, out_y[base+1]}, 32'd2);
      check("ramp_out3", {8'b0, out_y[base+2]}, 32'd4);
    end

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.org_valid = ($urandom_range(0, 3) == 0);
      bus.sound_org = 24'($urandom);
      bus.coef_we   = ($urandom_range(0, 3) == 0);
      bus.coef_addr = 4'($urandom);
      bus.coef_data = 24'($urandom);
      bus.fil_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.org_valid = 1'b0;
    bus.coef_we   = 1'b0;
    bus.fil_ready = 1'b1;
    wait_ready();
    repeat (3) step();
    check("drain_empty", exp_y.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/fir_seq_ctrl.md
FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NTAPS, default 16, meaning the number of filter taps; the block SHALL support powers of two only.
REQ-002 The block SHALL have parameter FRAC, default 23, meaning the number of coefficient fraction bits (Q1.23).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 The block SHALL have port sound_org, input, 24 bits: signed input sample.
REQ-006 The block SHALL have port org_valid, input, 1 bit: sound_org is valid.
REQ-007 The block SHALL have port org_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-008 The block SHALL have port coef_we, input, 1 bit: coefficient write strobe.
REQ-009 The block SHALL have port coef_addr, input, log2(NTAPS) bits: tap index.
REQ-010 The block SHALL have port coef_data, input, 24 bits: signed coefficient.
REQ-011 The block SHALL have port sound_fil, output, 24 bits: signed filtered sample, registered.
REQ-012 The block SHALL have port fil_valid, output, 1 bit: sound_fil is valid.
REQ-013 The block SHALL have port fil_ready, input, 1 bit: downstream accepts sound_fil.
REQ-014 The block SHALL have port fil_sat, output, 1 bit: the current sound_fil was clamped; qualified by fil_valid.
REQ-015 The block SHALL have port busy, output, 1 bit: the FSM is not in IDLE.

Function
REQ-016 The block SHALL compute y[n] = sum over k=0..NTAPS-1 of coef[k]*x[n-k] using exactly one 24x24 signed multiplier, time-multiplexed at one tap per cycle.
REQ-017 The block SHALL hold sample history in an NTAPS-entry circular buffer with a write pointer that wraps from NTAPS-1 to 0.
REQ-018 The FSM SHALL have exactly three states: IDLE, MAC and DONE.
REQ-019 In IDLE, org_ready SHALL be 1, and org_ready SHALL be 0 in all other states.
REQ-020 On an IDLE cycle with org_valid=1: sound_org SHALL be written at the write pointer, the pointer SHALL advance, the accumulator SHALL clear, the tap counter SHALL be set to 0, and the FSM SHALL go to MAC.
REQ-021 In MAC, each cycle SHALL add the 48-bit product coef[k]*x[n-k] into a signed accumulator of 48+log2(NTAPS) bits; tap 0 SHALL use the newly written sample.
REQ-022 After the tap NTAPS-1 cycle, the FSM SHALL go to DONE and SHALL register sound_fil = sat24(acc >>> FRAC), arithmetic shift, truncating toward negative infinity.
REQ-023 sat24 SHALL clamp to 0x7FFFFF or 0x800000, and fil_sat SHALL be set to 1 on a clamp and 0 otherwise.
REQ-024 In DONE, fil_valid SHALL be 1; sound_fil and fil_sat SHALL be held stable until fil_valid=1 and fil_ready=1, and the FSM SHALL then go to IDLE.
REQ-025 Latency SHALL be as follows: if a sample is accepted at cycle T, fil_valid SHALL be 1 first at cycle T+NTAPS+1 (T+17 at default).
REQ-026 Minimum spacing between accepted samples SHALL be NTAPS+2 cycles when fil_ready is held at 1.
REQ-027 A write with coef_we=1 SHALL take effect only in IDLE; the block SHALL ignore coef_we in MAC and DONE with no state change.
REQ-028 A coefficient write and a sample accept in the same IDLE cycle SHALL both occur, and the MAC pass SHALL use the new coefficient.
REQ-029 fil_ready=1 outside DONE SHALL have no effect, and org_valid=1 outside IDLE SHALL not be consumed.
REQ-030 busy SHALL be 1 in MAC and DONE.

Reset
REQ-031 When rst=0, asynchronously: the FSM SHALL be IDLE; the history buffer, all coefficients, the accumulator, the tap counter and the write pointer SHALL be 0; sound_fil SHALL be 0x000000; fil_valid, fil_sat and busy SHALL be 0; org_ready SHALL be 1 once rst=1.
REQ-032 Reset asserted during MAC or DONE SHALL abort the pass; no partial result SHALL ever be presented, and the first post-reset output SHALL reflect only post-reset samples.

Verification
REQ-033 The bench SHALL cover impulse: all coef=0x100000, sample 0x400000, then 17 samples of 0, fil_ready=1 -> outputs 1..16 are 0x080000 and output 17 is 0x000000, fil_sat=0.
REQ-034 The bench SHALL cover latency and backpressure: accept at cycle T -> fil_valid rises at T+17; holding fil_ready=0 for 5 cycles keeps sound_fil stable, org_ready=0 and busy=1.
REQ-035 The bench SHALL cover saturation: all coef=0x7FFFFF, 16 samples of 0x7FFFFF -> output 16 is 0x7FFFFF with fil_sat=1; the same coefficients with 16 samples of 0x800000 -> 0x800000 with fil_sat=1.
REQ-036 The bench SHALL cover a coefficient write while busy: coef_we=1 with coef_addr=0 and coef_data=0x7FFFFF during MAC is ignored; the same write in IDLE together with org_valid=1 is used in that pass.
REQ-037 The bench SHALL cover reset mid-MAC: rst=0 at tap 7 -> fil_valid=0 and sound_fil=0 immediately; after release, the impulse test of REQ-033 (after reloading coef) yields identical results.
REQ-038 The bench SHALL cover wrap-around: 40 consecutive ramp samples 1..40 with coef[k]=0x800000>>k (coef[0]=0x7FFFFF) -> each output matches the bit-accurate reference model across pointer wrap.
